// File: rtl/spi_cmd.sv
// spi_cmd: byte-oriented SPI/QSPI command engine for an N25Q-style serial flash.
// Shifts out 0..MAX_BYTES bytes MSB first, optionally reads one byte back, then deselects.
module spi_cmd #(
  parameter int MAX_BYTES       = 260,
  parameter int DESELECT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger,
  output logic                   busy,
  input  logic                   quad,
  input  logic [8:0]             data_in_count,
  input  logic                   data_out_count,
  input  logic [MAX_BYTES*8-1:0] data_in,
  output logic [7:0]             data_out,
  inout  wire  [3:0]             DQio,
  output logic                   S
);
  localparam int DW = MAX_BYTES*8;
  localparam int CW = $clog2(DW + DESELECT_CYCLES + 9);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DESEL} state_t;
  state_t state, state_nxt;

  logic          q_quad, q_read, last;
  logic [DW-1:0] sh;
  logic [CW-1:0] cnt, cnt_load, send_cyc, rx_cyc, sh_amt;
  logic [8:0]    nbytes;
  logic [7:0]    rx, rx_nxt;
  logic [3:0]    dq_o, dq_oe;

  assign nbytes   = (data_in_count > 9'(MAX_BYTES)) ? 9'(MAX_BYTES) : data_in_count;
  assign send_cyc = quad ? CW'({nbytes, 1'b0}) : CW'({nbytes, 3'b000});
  assign sh_amt   = CW'(8 * (MAX_BYTES - int'(nbytes)));
  // read length follows the live quad input only on the trigger edge
  assign rx_cyc   = ((state == IDLE) ? quad : q_quad) ? CW'(2) : CW'(8);
  assign last     = (cnt == CW'(1));
  assign rx_nxt   = q_quad ? {rx[3:0], DQio} : {rx[6:0], DQio[1]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (trigger) begin
        if (nbytes != '0)        state_nxt = SEND;
        else if (data_out_count) state_nxt = RECV;
        else                     state_nxt = DESEL;
      end
      SEND:    if (last) state_nxt = q_read ? RECV : DESEL;
      RECV:    if (last) state_nxt = DESEL;
      DESEL:   if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state_nxt)
      SEND:    cnt_load = send_cyc;
      RECV:    cnt_load = rx_cyc;
      default: cnt_load = CW'(DESELECT_CYCLES);
    endcase
  end

  always_comb begin
    S     = 1'b1;
    busy  = (state != IDLE);
    dq_o  = 4'b1100;
    dq_oe = q_quad ? 4'b0000 : 4'b1101;
    case (state)
      SEND: begin
        S = 1'b0;
        if (q_quad) begin
          dq_oe = 4'b1111;
          dq_o  = sh[DW-1 -: 4];
        end else begin
          dq_o[0] = sh[DW-1];
        end
      end
      RECV:    S = 1'b0;
      default: ;
    endcase
  end

  // cnt holds the cycles left in the current state, including the current one
  always_ff @(posedge clk) begin
    if (reset) begin
      q_quad   <= 1'b0;
      q_read   <= 1'b0;
      cnt      <= '0;
      rx       <= '0;
      data_out <= '0;
    end else begin
      if (state_nxt != state)  cnt <= cnt_load;
      else if (state != IDLE)  cnt <= cnt - CW'(1);
      if (state == IDLE && trigger) begin
        q_quad <= quad;
        q_read <= data_out_count;
      end
      if (state == RECV) begin
        rx <= rx_nxt;
        if (last) data_out <= rx_nxt;
      end
    end
  end

  // left-align the payload so the next bit/nibble is always at the top
  always_ff @(posedge clk) begin
    if (state == IDLE && trigger) sh <= data_in << sh_amt;
    else if (state == SEND)       sh <= q_quad ? (sh << 4) : (sh << 1);
  end

  for (genvar i = 0; i < 4; i++) begin : g_dq
    assign DQio[i] = dq_oe[i] ? dq_o[i] : 1'bz;
  end
endmodule

// File: tb/tb_spi_cmd.sv
// tb_spi_cmd: random + directed transfers against a byte-level flash/bus model, scoreboard checked.
module tb_spi_cmd;
  localparam int MB = 260;
  localparam int DS = 2;
  localparam int DW = MB*8;

  logic          clk = 1'b0, reset = 1'b1, trigger = 1'b0, quad = 1'b0, data_out_count = 1'b0;
  logic [8:0]    data_in_count = '0;
  logic [DW-1:0] data_in = '0;
  logic          busy, S;
  logic [7:0]    data_out;
  wire  [3:0]    dq;
  logic [3:0]    fl_oe = 4'b0000, fl_drv = 4'b0000;

  int n_checks = 0, n_fail = 0;

  spi_cmd #(.MAX_BYTES(MB), .DESELECT_CYCLES(DS)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .busy(busy), .quad(quad),
    .data_in_count(data_in_count), .data_out_count(data_out_count),
    .data_in(data_in), .data_out(data_out), .DQio(dq), .S(S));

  for (genvar i = 0; i < 4; i++) begin : g_fl
    assign dq[i] = fl_oe[i] ? fl_drv[i] : 1'bz;
  end

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { int busy_cyc; int s_cyc; logic [7:0] dout; } exp_t;
  exp_t       exp_q[$];
  logic [3:0] sv_q[$], sm_q[$];
  logic [7:0] tx_bytes[$];
  logic [7:0] exp_dout = 8'h00;
  bit         mon_en = 1'b0;

  // flash model: replies once the expected number of send clocks has gone by
  int         cur_send_cyc = 0;
  bit         cur_quad = 1'b0;
  logic [7:0] cur_reply = 8'h00;
  int         fc = 0;
  bit         s_prev = 1'b0;
  always begin
    @(posedge clk); #1;
    if (S === 1'b0) begin
      fc     = s_prev ? fc + 1 : 0;
      s_prev = 1'b1;
      fl_oe  = 4'b0000;
      if (fc >= cur_send_cyc) begin
        if (cur_quad && fc - cur_send_cyc < 2) begin
          fl_oe  = 4'b1111;
          fl_drv = (fc == cur_send_cyc) ? cur_reply[7:4] : cur_reply[3:0];
        end else if (!cur_quad && fc - cur_send_cyc < 8) begin
          fl_oe  = 4'b0010;
          fl_drv = {2'b00, cur_reply[7 - (fc - cur_send_cyc)], 1'b0};
        end
      end
    end else begin
      s_prev = 1'b0;
      fl_oe  = 4'b0000;
    end
  end

  // monitor: per-cycle bus stream while S is low, transaction totals when busy falls
  bit         prev_busy = 1'b0;
  int         bcnt = 0, scnt = 0, sbad = 0;
  exp_t       me;
  logic [3:0] mv, mm;
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        if (!prev_busy) begin bcnt = 0; scnt = 0; sbad = 0; end
        bcnt++;
        if (!S) begin
          scnt++;
          if (sv_q.size() == 0) sbad++;
          else begin
            mv = sv_q.pop_front();
            mm = sm_q.pop_front();
            if (((dq ^ mv) & mm) !== 4'b0000) sbad++;
          end
        end
      end else if (prev_busy) begin
        if (exp_q.size() == 0) chk("unexpected_txn", 1, 0);
        else begin
          me = exp_q.pop_front();
          chk("busy_cycles", bcnt, me.busy_cyc);
          chk("s_low_cycles", scnt, me.s_cyc);
          chk("bus_stream_bad_cycles", sbad, 0);
          chk("data_out", data_out, me.dout);
          sv_q.delete();
          sm_q.delete();
        end
      end
    end
    prev_busy = busy;
  end

  task automatic scramble();
    quad           = 1'($urandom);
    data_in_count  = 9'($urandom);
    data_out_count = 1'($urandom);
    data_in[31:0]  = $urandom;
  endtask

  // issue one command from tx_bytes; expected results come from the byte-level model
  task automatic issue(input bit q, input int n_raw, input bit rd, input logic [7:0] reply,
                       input bit retrig);
    int            n, send, rcv, t;
    logic [DW-1:0] din;
    logic [7:0]    b;
    exp_t          e;
    bit            stay;
    n    = (n_raw > MB) ? MB : n_raw;
    send = q ? 2*n : 8*n;
    rcv  = rd ? (q ? 2 : 8) : 0;
    for (int w = 0; w < DW/32; w++) din[32*w +: 32] = $urandom;
    for (int i = 0; i < n; i++) din[8*(n-1-i) +: 8] = tx_bytes[i];
    for (int i = 0; i < n; i++) begin
      b = tx_bytes[i];
      if (q) begin
        sv_q.push_back(b[7:4]); sm_q.push_back(4'hF);
        sv_q.push_back(b[3:0]); sm_q.push_back(4'hF);
      end else
        for (int k = 7; k >= 0; k--) begin
          sv_q.push_back({2'b11, 1'b0, b[k]}); sm_q.push_back(4'b1101);
        end
    end
    if (rd) begin
      if (q) begin
        sv_q.push_back(reply[7:4]); sm_q.push_back(4'hF);
        sv_q.push_back(reply[3:0]); sm_q.push_back(4'hF);
      end else
        for (int k = 7; k >= 0; k--) begin
          sv_q.push_back({2'b11, reply[k], 1'b0}); sm_q.push_back(4'hF);
        end
      exp_dout = reply;
    end
    e.busy_cyc = send + rcv + DS;
    e.s_cyc    = send + rcv;
    e.dout     = exp_dout;
    exp_q.push_back(e);

    @(negedge clk);
    cur_send_cyc   = send;
    cur_quad       = q;
    cur_reply      = reply;
    quad           = q;
    data_in_count  = 9'(n_raw);
    data_out_count = rd;
    data_in        = din;
    trigger        = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_trigger", busy, 1);
    @(negedge clk);
    trigger = retrig;
    scramble();
    @(negedge clk);
    trigger = 1'b0;
    scramble();
    t = 0;
    while (busy && t < e.busy_cyc + 20) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", busy, 0);
    stay = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy) stay = 1'b0;
    end
    chk("idle_after_done", stay, 1);
  endtask

  task automatic fill_rand(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_S", S, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_dq", {dq[3], dq[2], dq[0]}, 3'b110);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    tx_bytes = '{8'h9F};             issue(0, 1, 1, 8'h20, 0);  // RDID
    tx_bytes = '{8'h61, 8'hDF};      issue(0, 2, 0, 8'h00, 1);  // WRVECR
    tx_bytes = '{8'h65};             issue(1, 1, 1, 8'hAF, 0);  // quad read
    tx_bytes = '{8'h02, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 256; i++) tx_bytes.push_back(8'(i ^ 8'h5A));
    issue(1, 260, 0, 8'h00, 0);                                 // quad page program
    fill_rand(0);                    issue(0, 0, 0, 8'h00, 1);  // nothing sent
    fill_rand(0);                    issue(0, 0, 1, 8'hC3, 0);  // read only
    fill_rand(MB);                   issue(0, 300, 0, 8'h00, 0); // clamp
    fill_rand(MB);                   issue(1, 511, 1, 8'h3C, 0);

    for (int r = 0; r < 40; r++) begin
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 320) : $urandom_range(0, 6);
      fill_rand((n > MB) ? MB : n);
      issue(1'($urandom), n, 1'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0));
    end

    // reset in the middle of a long quad send
    tx_bytes = '{8'h9F};             issue(0, 1, 1, 8'h20, 0);
    mon_en = 1'b0;
    @(negedge clk);
    cur_quad = 1'b1; cur_send_cyc = 80;
    quad = 1'b1; data_in_count = 9'd40; data_out_count = 1'b0; data_in = '1;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (39) @(negedge clk);
    chk("mid_S_low", S, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_S", S, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_dq", {dq[3], dq[2], dq[0]}, 3'b110);
    exp_dout = 8'h00;
    reset    = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    tx_bytes = '{8'h05};             issue(1, 1, 1, 8'h81, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
